// File: rtl/imm_encode_stream_pkg.sv
// Shared immediate-type encoding, field positions and packing helpers.
package imm_encode_stream_pkg;

   // Same encoding as the core decoder's immediate-select field.
   typedef enum logic [1:0] {
      IMM_I = 2'd0,
      IMM_S = 2'd1,
      IMM_B = 2'd2,
      IMM_J = 2'd3
   } imm_type_e;

   // Instruction bit positions of the immediate fields. The extender
   // reads the same positions back out.
   localparam int I_HI      = 31;
   localparam int I_LO      = 20;
   localparam int S_HI_HI   = 31;
   localparam int S_HI_LO   = 25;
   localparam int S_LO_HI   = 11;
   localparam int S_LO_LO   = 7;
   localparam int B_SIGN    = 31;
   localparam int B_HI_HI   = 30;
   localparam int B_HI_LO   = 25;
   localparam int B_LO_HI   = 11;
   localparam int B_LO_LO   = 8;
   localparam int B_B11     = 7;
   localparam int J_SIGN    = 31;
   localparam int J_LO_HI   = 30;
   localparam int J_LO_LO   = 21;
   localparam int J_B11     = 20;
   localparam int J_MID_HI  = 19;
   localparam int J_MID_LO  = 12;

   // Overlay the immediate onto base; bits outside the fields pass through.
   function automatic logic [31:0] imm_pack(imm_type_e t, logic [31:0] base,
                                            logic [31:0] imm);
      logic [31:0] r;
      r = base;
      case (t)
         IMM_I: r[I_HI:I_LO] = imm[11:0];
         IMM_S: begin
            r[S_HI_HI:S_HI_LO] = imm[11:5];
            r[S_LO_HI:S_LO_LO] = imm[4:0];
         end
         IMM_B: begin
            r[B_SIGN]          = imm[12];
            r[B_HI_HI:B_HI_LO] = imm[10:5];
            r[B_LO_HI:B_LO_LO] = imm[4:1];
            r[B_B11]           = imm[11];
         end
         default: begin
            r[J_SIGN]            = imm[20];
            r[J_LO_HI:J_LO_LO]   = imm[10:1];
            r[J_B11]             = imm[11];
            r[J_MID_HI:J_MID_LO] = imm[19:12];
         end
      endcase
      return r;
   endfunction

   // An immediate is representable when every bit above the field's sign
   // bit copies it, and branch/jump targets are halfword aligned.
   function automatic logic imm_legal(imm_type_e t, logic [31:0] imm);
      logic ok;
      case (t)
         IMM_I, IMM_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
         IMM_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
         default:      ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/imm_encode_stream_fifo.sv
// Small synchronous FIFO with flush. Storage is reset so the head data
// reads as zero out of reset.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [AW-1:0] ptr_next(logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointer, occupancy and storage update; flush beats any transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop_ok) rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imm_encode_stream.sv
// Packs immediates into RISC-V instruction words, drops illegal requests
// into a saturating error count, and streams legal words with a byte address.
module imm_encode_stream
   import imm_encode_stream_pkg::*;
#(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int                 ERR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_imm_src,
   input  logic [31:0]       in_base,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt
);
   imm_type_e   imm_type;
   logic        legal;
   logic        accept;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [31:0] packed_word;

   assign imm_type    = imm_type_e'(in_imm_src);
   assign legal       = imm_legal(imm_type, in_imm);
   assign packed_word = imm_pack(imm_type, in_base, in_imm);

   // Handshakes are ignored while flushing.
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign accept    = in_valid & in_ready & ~clr;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready & ~clr;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (push),
      .push_data (packed_word),
      .pop       (pop),
      .head      (out_instr),
      .full      (full),
      .empty     (empty)
   );

   // Head address: steps one word per output handshake, wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) out_addr <= BASE_ADDR;
      else if (pop)      out_addr <= out_addr + ADDR_W'(4);
   end

   // Sticky error flag and saturating count; survive a flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else if (accept && !legal) begin
         err <= 1'b1;
         if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: doc/imm_encode_stream.md
# imm_encode_stream

Encoding counterpart of the core's immediate extender: packs a 32-bit immediate into the I/S/B/J bit positions of a RISC-V instruction word. Requests arrive through a valid/ready input and are legality-checked (range, alignment). Legal words are buffered in a 2-entry FIFO and streamed out with an auto-incrementing word address. Used by the program loader/debug path to write generated instructions into instruction memory.

## Interface
- `ADDR_W`, 32: width of `out_addr`.
- `BASE_ADDR`, 0: `out_addr` value after reset or `clr`.
- `ERR_W`, 8: width of the saturating error counter.

- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `clr`  in  1  synchronous flush: empties FIFO, `out_addr` := `BASE_ADDR`; error state kept.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_imm_src`  in  2  immediate type, `imm_type_e`: 0=I, 1=S, 2=B, 3=J.
- `in_base`  in  32  instruction with opcode/rd/rs1/rs2/funct fields; immediate-field bits ignored.
- `in_imm`  in  32  immediate, two's complement.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_instr`  out  32  encoded instruction at head.
- `out_addr`  out  `ADDR_W`  byte address of head word.
- `err`  out  1  sticky: an illegal request was seen.
- `err_cnt`  out  `ERR_W`  count of illegal requests, saturating.

## Operation
- Field packing, non-immediate bits from `in_base`:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Legality: I/S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0; J needs imm[31:20] all equal and imm[0]=0.
- Round-trip invariant: for every legal request, sign-extending the immediate back out of `out_instr` by type equals `in_imm`, and non-immediate bits equal `in_base`.
- Illegal request: handshake completes normally; nothing enqueued. `err` := 1. `err_cnt` += 1, holding at all-ones.
- `out_addr` advances by 4 on each output handshake, wrapping modulo 2^`ADDR_W`. Illegal requests consume no address.
- Priority: `rst_n` low > `clr` > normal. During `clr`, input and output handshakes are ignored.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_addr`=`BASE_ADDR`, `err`=0, `err_cnt`=0.
- Latency: a word accepted in cycle N appears at `out_valid` in cycle N+1. No combinational in→out bypass.
- `in_ready` = FIFO not full. It depends only on registered state, not on `out_ready`. A full FIFO refuses input even in a cycle that pops.
- Push and pop in the same cycle with 1 entry: count stays 1, head advances, `out_addr` += 4.
- Output holds `out_instr`/`out_addr` stable while `out_valid & !out_ready`.
- Reset or `clr` mid-stream drops buffered words with no partial output. `clr` does not clear `err`/`err_cnt`; only reset does.

## Structure
- Shared package holds `imm_type_e` (encoding identical to the core decoder's immediate-select field) and the field bit-position constants. The same constants are reused by the extender.
- Sub-module `sync_fifo` (parameterised width/depth, here 32×2, synchronous active-low reset, `clr`). The top level holds encode/legality logic, address counter and error counter.

## Test plan
- I: base 0x00000093, imm 0xFFFFFFFF, src 0 → `out_instr` 0xFFF00093, `out_addr` 0x0, one cycle after accept.
- B: base 0x00000063, imm 0xFFFFFFFC, src 2 → 0xFE000EE3. J: base 0x000000EF, imm 0x00000800, src 3 → 0x001000EF at addr 0x4.
- Illegal:
  - S with imm 0x00000800 → no output, `err`=1, `err_cnt`=1.
  - B with imm 0x3 → `err_cnt`=2.
  - Following legal word gets the next address.
- Backpressure:
  - With `out_ready`=0, push 3 legal words → `in_ready` falls after 2, third stalls.
  - Release → addresses 0x0, 0x4, 0x8 in order, data stable while stalled.
- 256+ illegal requests with `ERR_W`=8 → `err_cnt` holds 0xFF. `clr` with 2 buffered → `out_valid`=0 next cycle, `out_addr`=`BASE_ADDR`, `err_cnt` unchanged.
- Random legal (type, imm, base), 10k requests → round-trip invariant holds. `rst_n` low mid-stream → all reset values next cycle.
